// File: rtl/int2flt_pkg.sv
// int2flt_pkg: shared types and default widths for the int2flt_seq converter.
// Optional round-to-nearest-even build switch: INT2FLT_RNE_EN.
package int2flt_pkg;

  localparam int INT_W_DEF = 16;
  localparam int EXP_W_DEF = 5;
  localparam int MAN_W_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    NORM,
    ROUND,
    DONE
  } state_t;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] bexp;
    logic [MAN_W_DEF-1:0] mant;
  } flt_t;

endpackage

// File: rtl/int2flt_seq_if.sv
// int2flt_seq_if: request/result handshake bundle of the converter.
// master drives req/din; slave returns ready/done/dout.
interface int2flt_seq_if
  import int2flt_pkg::*;
#(
  parameter int INT_W = INT_W_DEF,
  parameter int OUT_W = 1 + EXP_W_DEF + MAN_W_DEF
) ();

  logic             req;
  logic [INT_W-1:0] din;
  logic             ready;
  logic             done;
  logic [OUT_W-1:0] dout;

  modport master (
    output req,
    output din,
    input  ready,
    input  done,
    input  dout
  );

  modport slave (
    input  req,
    input  din,
    output ready,
    output done,
    output dout
  );

endinterface

// File: rtl/flt_round.sv
// flt_round: turns a normalised magnitude + exponent into {exp, mant}.
// INT2FLT_RNE_EN selects round-to-nearest-even; otherwise truncation.
module flt_round
  import int2flt_pkg::*;
#(
  parameter int INT_W = INT_W_DEF,
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic [INT_W-2:0] frac,
  input  logic [EXP_W-1:0] bexp,
  output logic [EXP_W-1:0] rexp,
  output logic [MAN_W-1:0] rmant
);

  // frac is padded below so narrow inputs simply get zero guard/sticky
  localparam int W = INT_W + MAN_W + 1;

  logic [W-1:0]     ext;
  logic [MAN_W-1:0] mant;
  logic             guard;
  logic             sticky;
  logic             inc;
  logic [MAN_W:0]   sum;

  assign ext    = {frac, {(MAN_W+2){1'b0}}};
  assign mant   = ext[W-1 -: MAN_W];
  assign guard  = ext[W-1-MAN_W];
  assign sticky = |ext[W-2-MAN_W:0];

`ifdef INT2FLT_RNE_EN
  assign inc = guard & (sticky | mant[0]);
`else
  logic unused_gs;
  assign unused_gs = guard | sticky;
  assign inc       = 1'b0;
`endif

  // carry out of the mantissa leaves it zero and bumps the exponent
  assign sum   = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
  assign rmant = sum[MAN_W-1:0];
  assign rexp  = bexp + {{(EXP_W-1){1'b0}}, sum[MAN_W]};

endmodule

// File: rtl/int2flt_seq.sv
// int2flt_seq: multi-cycle signed integer to float converter.
// Rounding mode chosen in flt_round via INT2FLT_RNE_EN.
module int2flt_seq
  import int2flt_pkg::*;
#(
  parameter int INT_W = INT_W_DEF,
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int BIAS  = 2**(EXP_W-1) - 1
) (
  input logic          clk,
  input logic          reset,
  int2flt_seq_if.slave bus
);

  // largest biased exponent must stay below the all-ones (Inf) code
  if (BIAS + INT_W - 1 > 2**EXP_W - 2) begin : g_exp_range
    $error("int2flt_seq: EXP_W too narrow for INT_W/BIAS");
  end

  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(BIAS + INT_W - 1);

  state_t           state;
  logic             sign;
  logic [INT_W-1:0] mag;
  logic [EXP_W-1:0] bexp;
  logic [EXP_W-1:0] rexp;
  logic [MAN_W-1:0] rmant;

  flt_round #(
    .INT_W (INT_W),
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .frac  (mag[INT_W-2:0]),
    .bexp  (bexp),
    .rexp  (rexp),
    .rmant (rmant)
  );

  // control FSM; a zero operand skips NORM and is forced to +0 in ROUND
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sign      <= 1'b0;
      mag       <= '0;
      bexp      <= '0;
      bus.ready <= 1'b1;
      bus.done  <= 1'b0;
      bus.dout  <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            mag       <= bus.din;
            bus.ready <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          sign  <= mag[INT_W-1];
          mag   <= mag[INT_W-1] ? -mag : mag;
          bexp  <= EXP_TOP;
          state <= (mag == '0) ? ROUND : NORM;
        end
        NORM: begin
          if (mag[INT_W-1]) begin
            state <= ROUND;
          end else begin
            mag  <= mag << 1;
            bexp <= bexp - EXP_W'(1);
          end
        end
        ROUND: begin
          bus.dout <= (mag == '0) ? '0 : {sign, rexp, rmant};
          bus.done <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int2flt_seq.sv
// tb_int2flt_seq: scoreboard bench for int2flt_seq at 16/5/10/15.
// Honours INT2FLT_RNE_EN in its reference model.
module tb_int2flt_seq;

  localparam int IW = 16;
  localparam int EW = 5;
  localparam int MW = 10;
  localparam int BS = 15;

  typedef struct {
    logic [15:0] din;
    logic [15:0] res;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sbq[$];
  logic [15:0] last_exp = '0;

  int2flt_seq_if #(.INT_W(IW), .OUT_W(1+EW+MW)) bus ();

  int2flt_seq #(
    .INT_W (IW),
    .EXP_W (EW),
    .MAN_W (MW),
    .BIAS  (BS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int top_bit(input longint m);
    int e;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    return e;
  endfunction

  function automatic logic [15:0] ref_val(input logic [15:0] v);
    longint m;
    longint q;
    int     e;
    logic   s;
    s = v[15];
    m = s ? (longint'(65536) - longint'(v)) : longint'(v);
    if (m == 0) return 16'h0000;
    e = top_bit(m);
    if (e <= MW) begin
      q = m << (MW - e);
    end else begin
      int sh;
      sh = e - MW;
      q  = m >> sh;
`ifdef INT2FLT_RNE_EN
      begin
        longint rem;
        longint half;
        rem  = m - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
        if (q == (longint'(1) << (MW + 1))) begin
          q = q >> 1;
          e++;
        end
      end
`endif
    end
    return {s, 5'(e + BS), 10'(q - 1024)};
  endfunction

  function automatic int ref_lat(input logic [15:0] v);
    longint m;
    m = v[15] ? (longint'(65536) - longint'(v)) : longint'(v);
    if (m == 0) return 2;
    return (IW - 1 - top_bit(m)) + 3;
  endfunction

  // monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.done === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: dout=%h required no done", bus.dout);
      end else begin
        e = sbq.pop_front();
        if (bus.dout !== e.res) begin
          errors++;
          $display("FAIL dout din=%h: got %h required %h", e.din, bus.dout, e.res);
        end
        checks++;
        if (cyc - e.acc != e.lat) begin
          errors++;
          $display("FAIL latency din=%h: got %0d required %0d", e.din, cyc - e.acc, e.lat);
        end
        last_exp = e.res;
      end
    end
  end

  task automatic run_conv(input logic [15:0] v, input bit hold);
    int   n;
    exp_t e;
    @(negedge clk);
    #1;
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout din=%h: ready=%b required 1", v, bus.ready);
      return;
    end
    checks++;
    if (bus.dout !== last_exp) begin
      errors++;
      $display("FAIL dout_hold: got %h required %h", bus.dout, last_exp);
    end
    e.din = v;
    e.res = ref_val(v);
    e.lat = ref_lat(v);
    e.acc = cyc + 1;
    sbq.push_back(e);
    bus.req = 1'b1;
    bus.din = v;
    @(negedge clk);
    #1;
    if (!hold) bus.req = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      if (hold) bus.din = 16'($urandom);
      @(negedge clk);
      #1;
      n++;
    end
    bus.req = 1'b0;
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL done_timeout din=%h: no done, required one", v);
      sbq.delete();
      return;
    end
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_done din=%h: got %b required 0", v, bus.ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after din=%h: got %b required 1", v, bus.ready);
    end
  endtask

  task automatic chk_idle(input string name);
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b required 1", name, bus.ready);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s done: got %b required 0", name, bus.done);
    end
    checks++;
    if (bus.dout !== 16'h0000) begin
      errors++;
      $display("FAIL %s dout: got %h required 0000", name, bus.dout);
    end
  endtask

  initial begin
    logic [15:0] v;
    bus.req = 1'b0;
    bus.din = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_idle("reset_state");
    reset = 1'b1;

    run_conv(16'h0001, 1'b0);
    run_conv(16'hFFFF, 1'b0);
    run_conv(16'h0000, 1'b0);
    run_conv(16'h8000, 1'b0);
    run_conv(16'd2051, 1'b0);
    run_conv(16'd4095, 1'b0);
    run_conv(16'h7FFF, 1'b0);
    run_conv(16'h8001, 1'b0);
    run_conv(16'h0003, 1'b1);
    run_conv(16'hF001, 1'b1);

    for (int i = 0; i < 60; i++) begin
      v = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) v = -v;
      run_conv(v, $urandom_range(0, 3) == 0);
    end

    // abort a din=1 conversion while it is normalising
    @(negedge clk);
    #1;
    bus.req = 1'b1;
    bus.din = 16'h0001;
    @(negedge clk);
    #1;
    bus.req = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_idle("mid_reset");
    last_exp = '0;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (25) @(negedge clk);
    run_conv(16'h0002, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
